// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and constants for the PC redirect unit: FSM states, target-source
// encoding and the fetch increment.
package pc_redirect_unit_pkg;

    typedef enum logic [1:0] {
        PCR_RUN    = 2'd0,
        PCR_FLUSH  = 2'd1,
        PCR_HALTED = 2'd2
    } pcr_state_e;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_BR   = 2'd1,
        TGT_JAL  = 2'd2,
        TGT_JALR = 2'd3
    } tgt_src_e;

    localparam logic [31:0] PC_INC = 32'd4;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_unit_pc_target_gen.sv
// Combinational redirect-target generator: picks the control-transfer source,
// forms the target address and flags targets that are not 4-byte aligned.
module pc_target_gen
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] jalr_base,
    output logic            req_any,
    output logic [XLEN-1:0] tgt,
    output logic            misaligned
);

    tgt_src_e        src;
    logic [XLEN-1:0] pc_rel_sum;
    logic [XLEN-1:0] jalr_sum;

    assign pc_rel_sum = ex_pc + ex_imm;
    assign jalr_sum   = jalr_base + ex_imm;
    assign req_any    = branch_taken | jump | jalr;

    always_comb begin
        src = TGT_NONE;
        if (jalr) begin
            src = TGT_JALR;
        end else if (jump) begin
            src = TGT_JAL;
        end else if (branch_taken) begin
            src = TGT_BR;
        end
    end

    always_comb begin
        tgt = pc_rel_sum;
        case (src)
            TGT_JALR: tgt = {jalr_sum[XLEN-1:1], 1'b0};
            TGT_JAL,
            TGT_BR:   tgt = pc_rel_sum;
            default:  tgt = pc_rel_sum;
        endcase
    end

    // Alignment is judged after the JALR bit-0 mask, so only bit 1 can trip JALR.
    assign misaligned = is_misaligned(tgt[1:0]);

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: consumes EX-stage branch/jump decisions, redirects fetch,
// flushes wrong-path stages, traps misaligned targets and freezes on halt.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            jalr,
    input  logic            halt,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] jalr_base,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            misalign_err,
    output logic            halted,
    output logic [31:0]     redirect_count
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    pcr_state_e      state;
    pcr_state_e      state_nxt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] flush_cnt_nxt;

    logic            req_any;
    logic            tgt_misaligned;
    logic [XLEN-1:0] tgt;

    logic            req;
    logic            do_halt;
    logic            do_misalign;
    logic            do_redirect;
    logic [XLEN-1:0] pc_nxt;

    pc_target_gen #(
        .XLEN (XLEN)
    ) u_tgt (
        .branch_taken (branch_taken),
        .jump         (jump),
        .jalr         (jalr),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .jalr_base    (jalr_base),
        .req_any      (req_any),
        .tgt          (tgt),
        .misaligned   (tgt_misaligned)
    );

    assign pc_plus4 = pc_out + XLEN'(PC_INC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PCR_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            PCR_RUN: begin
                if (do_halt || do_misalign) begin
                    state_nxt = PCR_HALTED;
                end else if (do_redirect) begin
                    // A single-cycle flush window means no FLUSH residency at all.
                    state_nxt     = (FLUSH_CYCLES > 1) ? PCR_FLUSH : PCR_RUN;
                    flush_cnt_nxt = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            PCR_FLUSH: begin
                flush_cnt_nxt = flush_cnt - CNT_W'(1);
                if (flush_cnt <= CNT_W'(1)) begin
                    state_nxt = PCR_RUN;
                end
            end
            PCR_HALTED: state_nxt = PCR_HALTED;
            default:    state_nxt = PCR_RUN;
        endcase
    end

    always_comb begin
        req         = (state == PCR_RUN) && req_any;
        do_halt     = (state == PCR_RUN) && halt;
        do_misalign = req && !halt && tgt_misaligned;
        do_redirect = req && !halt && !tgt_misaligned;

        flush_ifid  = do_misalign || do_redirect;
        flush_idex  = do_misalign || do_redirect;
        halted      = (state == PCR_HALTED);

        pc_nxt = pc_out;
        case (state)
            PCR_RUN: begin
                if (do_halt || do_misalign) begin
                    pc_nxt = pc_out;
                end else if (do_redirect) begin
                    pc_nxt = tgt;
                end else if (!stall) begin
                    pc_nxt = pc_plus4;
                end
            end
            PCR_FLUSH: begin
                if (!stall) begin
                    pc_nxt = pc_plus4;
                end
            end
            default: pc_nxt = pc_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out         <= RESET_PC;
            flush_cnt      <= '0;
            misalign_err   <= 1'b0;
            redirect_count <= '0;
        end else begin
            pc_out       <= pc_nxt;
            flush_cnt    <= flush_cnt_nxt;
            misalign_err <= do_misalign;
            if (do_redirect && (redirect_count != '1)) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a vector table walked cycle by cycle plus
// hand-written sequences for halt freeze, reset-in-halt and misaligned targets.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump, jalr, halt;
    logic [31:0] ex_pc, ex_imm, jalr_base;
    logic [31:0] pc_out, pc_plus4, redirect_count;
    logic        flush_ifid, flush_idex, misalign_err, halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .XLEN         (32),
        .RESET_PC     (32'h0),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .jalr           (jalr),
        .halt           (halt),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .jalr_base      (jalr_base),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .misalign_err   (misalign_err),
        .halted         (halted),
        .redirect_count (redirect_count)
    );

    typedef struct {
        logic        rst, stall, bt, jmp, jr, hlt;
        logic [31:0] ex_pc, ex_imm, base;
        logic        chk;
        logic [31:0] pc;
        logic        fl, mis, hlted;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, s, b, j, jr, h,
                                input logic [31:0] p, i, bs,
                                input logic c,
                                input logic [31:0] epc,
                                input logic f, m, hd,
                                input logic [31:0] cn);
        vec_t v;
        v.rst = r; v.stall = s; v.bt = b; v.jmp = j; v.jr = jr; v.hlt = h;
        v.ex_pc = p; v.ex_imm = i; v.base = bs;
        v.chk = c; v.pc = epc; v.fl = f; v.mis = m; v.hlted = hd; v.cnt = cn;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, b, j, jr, h,
                         input logic [31:0] p, i, bs);
        rst = r; stall = s; branch_taken = b; jump = j; jalr = jr; halt = h;
        ex_pc = p; ex_imm = i; jalr_base = bs;
    endtask

    task automatic check_all(input int idx, input logic [31:0] epc,
                             input logic f, m, hd, input logic [31:0] cn);
        check("pc_out", idx, pc_out, epc);
        check("pc_plus4", idx, pc_plus4, epc + 32'd4);
        check("flush_ifid", idx, {31'd0, flush_ifid}, {31'd0, f});
        check("flush_idex", idx, {31'd0, flush_idex}, {31'd0, f});
        check("misalign_err", idx, {31'd0, misalign_err}, {31'd0, m});
        check("halted", idx, {31'd0, halted}, {31'd0, hd});
        check("redirect_count", idx, redirect_count, cn);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        //            rst s bt j jr h  ex_pc         ex_imm     base      chk pc          fl m hd cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   0, 32'h0,   0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h0,   0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h4,   0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h8,   0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'hC,   0, 0, 0, 0);
        vecs[5]  = mk(0, 0, 1, 0, 0, 0, 32'h8,        32'h20,    32'h0,   1, 32'h10,  1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 0, 0, 0, 32'h8,        32'h20,    32'h0,   1, 32'h28,  0, 0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h2C,  0, 0, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'h4,     32'h101, 1, 32'h30,  1, 0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h104, 0, 0, 0, 2);
        vecs[10] = mk(0, 0, 1, 1, 1, 0, 32'h1000,     32'h10,    32'h200, 1, 32'h108, 1, 0, 0, 2);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h210, 0, 0, 0, 3);
        vecs[12] = mk(0, 1, 1, 0, 0, 0, 32'h300,      32'h100,   32'h0,   1, 32'h214, 1, 0, 0, 3);
        vecs[13] = mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h400, 0, 0, 0, 4);
        vecs[14] = mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h400, 0, 0, 0, 4);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h400, 0, 0, 0, 4);
        vecs[16] = mk(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h20,   32'h0,   1, 32'h404, 1, 0, 0, 4);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h10,  0, 0, 0, 5);
        vecs[18] = mk(0, 0, 1, 0, 0, 0, 32'h0,        32'h3C,    32'h0,   1, 32'h14,  1, 0, 0, 5);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,     32'h0,   1, 32'h3C,  0, 0, 0, 6);
        vecs[20] = mk(0, 0, 1, 0, 0, 0, 32'h0,        32'h3C,    32'h0,   1, 32'h0,   1, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,     32'h0,   1, 32'h3C,  0, 0, 0, 1);
        vecs[22] = mk(0, 0, 1, 0, 0, 1, 32'h0,        32'h8,     32'h0,   1, 32'h40,  0, 0, 0, 1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].bt, vecs[i].jmp, vecs[i].jr,
                  vecs[i].hlt, vecs[i].ex_pc, vecs[i].ex_imm, vecs[i].base);
            #1;
            if (vecs[i].chk) begin
                check_all(i, vecs[i].pc, vecs[i].fl, vecs[i].mis, vecs[i].hlted, vecs[i].cnt);
            end
        end

        // Halted: everything frozen regardless of redirect/stall/halt activity.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(0, k[0], 1, k[1], k[2], 1, 32'h0, 32'h100, 32'h0);
            #1;
            check_all(100 + k, 32'h40, 0, 0, 1, 1);
        end

        // Reset out of HALTED, then free-run resumes.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all(200, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check_all(201, 32'h4, 0, 0, 0, 0);

        // JAL to an unaligned target: flush now, error pulse next cycle, then halted.
        drive(0, 0, 0, 1, 0, 0, 32'h0, 32'h6, 32'h0);
        #1;
        check_all(202, 32'h4, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all(203, 32'h4, 0, 1, 1, 0);
        @(negedge clk);
        #1;
        check_all(204, 32'h4, 0, 0, 1, 0);

        // JALR whose masked target still has bit 1 set is misaligned.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h103);
        #1;
        check_all(300, 32'h0, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all(301, 32'h0, 0, 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

endmodule
